add_multicycle: RTL and testbench
=================================

Name: add_multicycle

Overview:
- Parametrised, sequential successor to the 4-bit ripple adder (ADD_4).
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, with the carry held in a register between chunks, so wide adds reuse one narrow adder slice.
- Uses a start/busy/done handshake; sits between operand registers and the result bus in the ALU datapath.
- Also provides a subtract mode and a signed-overflow flag, which ADD_4 does not have.

Parameters:
- WIDTH, 32, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per clock cycle.
- NCHUNK (localparam), WIDTH/CHUNK, cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- sub  input  1  0: res = a+b+cin; 1: res = a-b (a + ~b + 1, cin ignored).
- cin  input  1  carry-in for add mode.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; res/cout/ovf valid from this cycle.
- res  output  WIDTH  result.
- cout  output  1  carry out of the MSB. In sub mode, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Async reset (rst=1, immediate, independent of clk):
  - state=IDLE; busy=0, done=0, res=0, cout=0, ovf=0.
  - Internal chunk counter, carry register and operand shift registers cleared.
- States: IDLE, RUN.
- IDLE:
  - If start=1 at a rising edge, the block latches a, b^{WIDTH{sub}}, carry=sub?1:cin, chunk index=0.
  - It then enters RUN with busy=1.
  - Otherwise it stays idle; res/cout/ovf hold their last values.
- RUN, each edge:
  - Processes chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) as a_k + b_k + carry.
  - Writes the CHUNK-bit sum into the internal result register and updates carry.
  - k increments.
- Last chunk (k=NCHUNK-1):
  - At that edge, res, cout=final carry and ovf are updated.
  - ovf = (a_msb == b'_msb) && (res_msb != a_msb), where b' is the latched (possibly inverted) B.
  - done=1 for exactly the following cycle; busy=0; state returns to IDLE.
- Latency: start accepted at edge t. busy is high after edge t through edge t+NCHUNK. Results and done appear after edge t+NCHUNK. NCHUNK=1 gives single-cycle latency.
- res is not updated incrementally; intermediate chunks stay internal, so res holds the previous result until done.
- start while busy=1 is ignored; no queueing.
- start in the same cycle as done=1 is accepted, because busy=0. done drops next cycle and busy rises.
- Changes on a, b, sub or cin during RUN have no effect; operands are captured only at acceptance.
- Reset mid-operation aborts immediately: outputs go to their reset values, no done pulse, and the block returns to IDLE.
- Widths: all arithmetic is modulo 2^WIDTH; carry beyond the MSB is reported only on cout.

Test Plan:
- WIDTH=8, CHUNK=4, sub=0, cin=0, a=0x01, b=0x02, start one cycle -> busy for 2 cycles, then done pulse with res=0x03, cout=0, ovf=0.
- WIDTH=8, CHUNK=4: a=0xFF, b=0x01, cin=0 -> res=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 -> res=0x80, ovf=1, cout=0.
- WIDTH=8, CHUNK=4, sub=1: a=0x03, b=0x05 -> res=0xFE, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01 -> res=0x7F, ovf=1, cout=1.
- Defaults (32/4), a=0x0000_0003, b=0x0000_0002, cin=1 -> done exactly 8 cycles after the start edge, res=0x0000_0006. A second start pulsed mid-run is ignored; a start held during the done cycle launches a new op.
- Operands changed during RUN (a=0x10→0xFF after the accepting edge) -> result uses the latched 0x10.
- rst asserted 3 cycles into a 32/4 op -> busy, done and res drop to 0 immediately, no done pulse. A subsequent start completes normally.

Source files
------------

// File: rtl/add_multicycle.sv
// Multi-cycle add/subtract unit: a WIDTH-bit operation is processed CHUNK bits
// per clock through one narrow adder slice, with a start/busy/done handshake.
module add_multicycle #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res,
   output logic             cout,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [KW-1:0]    k_q, k_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;

   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK:0]   sum;

   // The single shared adder slice; operands stay in place and are indexed by k.
   assign a_chunk = a_q[k_q*CHUNK +: CHUNK];
   assign b_chunk = b_q[k_q*CHUNK +: CHUNK];
   assign sum     = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      res_d   = res_q;
      k_d     = k_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b ^ {WIDTH{sub}};
               carry_d = sub ? 1'b1 : cin;
               k_d     = '0;
               acc_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d[k_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
            carry_d = sum[CHUNK];
            k_d     = k_q + 1'b1;
            if (k_q == K_LAST) begin
               // res only changes here, so the bus never sees a partial sum.
               res_d   = acc_d;
               cout_d  = sum[CHUNK];
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[CHUNK-1] != a_q[WIDTH-1]);
               done_d  = 1'b1;
               k_d     = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         res_q   <= '0;
         k_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = done_q;
   assign res  = res_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_add_multicycle.sv
// Bench for add_multicycle: an 8/4 and a 32/4 instance, each checked every
// cycle against a full-width arithmetic model, plus literal expectations.
module tb_add_multicycle;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // 8-bit instance
   logic       rst8 = 1'b1, start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, cout8, ovf8;
   logic [7:0] res8;

   // 32-bit instance
   logic        rst32 = 1'b1, start32 = 1'b0, sub32 = 1'b0, cin32 = 1'b0;
   logic [31:0] a32 = '0, b32 = '0;
   logic        busy32, done32, cout32, ovf32;
   logic [31:0] res32;

   add_multicycle #(.WIDTH(8), .CHUNK(4)) dut8 (
      .clk(clk), .rst(rst8), .start(start8), .sub(sub8), .cin(cin8),
      .a(a8), .b(b8), .busy(busy8), .done(done8), .res(res8),
      .cout(cout8), .ovf(ovf8)
   );

   add_multicycle #(.WIDTH(32), .CHUNK(4)) dut32 (
      .clk(clk), .rst(rst32), .start(start32), .sub(sub32), .cin(cin32),
      .a(a32), .b(b32), .busy(busy32), .done(done32), .res(res32),
      .cout(cout32), .ovf(ovf32)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Returns {ovf, cout, res} for a w-bit operation, computed at full width.
   function automatic logic [65:0] golden(input int w, input logic [31:0] ga,
                                          input logic [31:0] gb, input logic gs,
                                          input logic gc);
      logic [63:0] mask, bp, full, r;
      logic        o;
      mask = (64'd1 << w) - 64'd1;
      bp   = (gs ? ~{32'd0, gb} : {32'd0, gb}) & mask;
      full = {32'd0, ga} + bp + (gs ? 64'd1 : {63'd0, gc});
      r    = full & mask;
      o    = (ga[w-1] == bp[w-1]) && (r[w-1] != ga[w-1]);
      return {o, full[w], r};
   endfunction

   // Transaction-level model: remaining-cycle count plus pending result.
   int          m8_cnt = 0, m32_cnt = 0;
   logic        m8_done = 0, m8_cout = 0, m8_ovf = 0;
   logic        m32_done = 0, m32_cout = 0, m32_ovf = 0;
   logic [63:0] m8_res = '0, m32_res = '0;
   logic [65:0] m8_pend = '0, m32_pend = '0;

   always @(posedge clk or posedge rst8) begin
      if (rst8) begin
         m8_cnt <= 0; m8_done <= 0; m8_res <= '0; m8_cout <= 0; m8_ovf <= 0;
      end else begin
         m8_done <= 0;
         if (m8_cnt > 0) begin
            m8_cnt <= m8_cnt - 1;
            if (m8_cnt == 1) begin
               {m8_ovf, m8_cout, m8_res} <= m8_pend;
               m8_done <= 1;
            end
         end else if (start8) begin
            m8_pend <= golden(8, {24'd0, a8}, {24'd0, b8}, sub8, cin8);
            m8_cnt  <= 2;
         end
      end
   end

   always @(posedge clk or posedge rst32) begin
      if (rst32) begin
         m32_cnt <= 0; m32_done <= 0; m32_res <= '0; m32_cout <= 0; m32_ovf <= 0;
      end else begin
         m32_done <= 0;
         if (m32_cnt > 0) begin
            m32_cnt <= m32_cnt - 1;
            if (m32_cnt == 1) begin
               {m32_ovf, m32_cout, m32_res} <= m32_pend;
               m32_done <= 1;
            end
         end else if (start32) begin
            m32_pend <= golden(32, a32, b32, sub32, cin32);
            m32_cnt  <= 8;
         end
      end
   end

   always @(negedge clk) begin
      chk("busy8",  {63'd0, busy8},  {63'd0, (m8_cnt > 0)});
      chk("done8",  {63'd0, done8},  {63'd0, m8_done});
      chk("res8",   {56'd0, res8},   m8_res);
      chk("cout8",  {63'd0, cout8},  {63'd0, m8_cout});
      chk("ovf8",   {63'd0, ovf8},   {63'd0, m8_ovf});
      chk("busy32", {63'd0, busy32}, {63'd0, (m32_cnt > 0)});
      chk("done32", {63'd0, done32}, {63'd0, m32_done});
      chk("res32",  {32'd0, res32},  m32_res);
      chk("cout32", {63'd0, cout32}, {63'd0, m32_cout});
      chk("ovf32",  {63'd0, ovf32},  {63'd0, m32_ovf});
   end

   task automatic wait_done8(output int cyc);
      cyc = 0;
      while (cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (done8) return;
      end
      n_checks++; n_errors++;
      $display("FAIL done8_timeout: no done after %0d cycles", cyc);
   endtask

   task automatic wait_done32(output int cyc);
      cyc = 0;
      while (cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (done32) return;
      end
      n_checks++; n_errors++;
      $display("FAIL done32_timeout: no done after %0d cycles", cyc);
   endtask

   task automatic op8(input string nm, input logic [7:0] ta, input logic [7:0] tb_,
                      input logic ts, input logic tc, input logic [7:0] er,
                      input logic ec, input logic eo);
      int cyc;
      @(posedge clk); #1;
      a8 = ta; b8 = tb_; sub8 = ts; cin8 = tc; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      wait_done8(cyc);
      chk({nm, "_lat"},  64'(cyc), 64'd3);
      chk({nm, "_res"},  {56'd0, res8}, {56'd0, er});
      chk({nm, "_cout"}, {63'd0, cout8}, {63'd0, ec});
      chk({nm, "_ovf"},  {63'd0, ovf8}, {63'd0, eo});
   endtask

   task automatic op32(input string nm, input logic [31:0] ta, input logic [31:0] tb_,
                       input logic ts, input logic tc, input logic [31:0] er,
                       input logic ec, input logic eo);
      int cyc;
      @(posedge clk); #1;
      a32 = ta; b32 = tb_; sub32 = ts; cin32 = tc; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      wait_done32(cyc);
      chk({nm, "_lat"},  64'(cyc), 64'd9);
      chk({nm, "_res"},  {32'd0, res32}, {32'd0, er});
      chk({nm, "_cout"}, {63'd0, cout32}, {63'd0, ec});
      chk({nm, "_ovf"},  {63'd0, ovf32}, {63'd0, eo});
   endtask

   initial begin
      int cyc;
      int seen;

      repeat (2) @(negedge clk);
      chk("rst_busy8", {63'd0, busy8}, 64'd0);
      chk("rst_res32", {32'd0, res32}, 64'd0);
      chk("rst_done32", {63'd0, done32}, 64'd0);
      @(posedge clk); #1;
      rst8 = 1'b0; rst32 = 1'b0;

      op8("add_small",  8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
      op8("add_wrap",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      op8("add_ovf",    8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      op8("sub_borrow", 8'h03, 8'h05, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
      op8("sub_ovf",    8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
      op8("add_cin",    8'h7F, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);

      // Start pulsed mid-run is ignored; start held during done launches a new op.
      @(posedge clk); #1;
      a32 = 32'h3; b32 = 32'h2; sub32 = 1'b0; cin32 = 1'b1; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      a32 = 32'hAAAA_AAAA; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      wait_done32(cyc);
      chk("midstart_res", {32'd0, res32}, 64'h6);
      a32 = 32'h5; b32 = 32'h7; cin32 = 1'b0; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      wait_done32(cyc);
      chk("b2b_lat", 64'(cyc), 64'd9);
      chk("b2b_res", {32'd0, res32}, 64'hC);

      op32("add32", 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b1, 32'h0000_0006, 1'b0, 1'b0);

      // Operands altered after acceptance must not affect the result.
      @(posedge clk); #1;
      a32 = 32'h10; b32 = 32'h01; sub32 = 1'b0; cin32 = 1'b0; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0; a32 = 32'hFF; b32 = 32'hFF; sub32 = 1'b1; cin32 = 1'b1;
      wait_done32(cyc);
      chk("latched_res", {32'd0, res32}, 64'h11);
      chk("latched_cout", {63'd0, cout32}, 64'd0);
      sub32 = 1'b0;

      // Reset three cycles into an operation aborts it.
      @(posedge clk); #1;
      a32 = 32'h100; b32 = 32'h200; cin32 = 1'b0; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst32 = 1'b1;
      #1;
      chk("abort_busy", {63'd0, busy32}, 64'd0);
      chk("abort_done", {63'd0, done32}, 64'd0);
      chk("abort_res",  {32'd0, res32}, 64'd0);
      @(posedge clk); #1;
      rst32 = 1'b0;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (done32) seen++;
      end
      chk("abort_no_done", 64'(seen), 64'd0);
      op32("after_rst", 32'h1234, 32'h1111, 1'b0, 1'b0, 32'h2345, 1'b0, 1'b0);
      op32("sub32", 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
